// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared widths and the writeback request record used by the
// regfile writeback arbiter and its bench.
package regfile_pkg;
    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int NUM_REGS    = 32;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester bundle plus the regfile write
// bus and hazard outputs of the arbiter.
//   master : requester side (drives req_valid/req_reg/req_data/wb_hold)
//   slave  : arbiter side (drives req_ready, rf_*, pending, stall_cnt)
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_reg;
    logic [NUM_REQ-1:0][XLEN-1:0]        req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                wb_hold;
    logic                                rf_write;
    logic [REG_ADDR_W-1:0]               rf_writeReg;
    logic [XLEN-1:0]                     rf_writeData;
    logic [NUM_REGS-1:0]                 pending;
    logic [NUM_REQ-1:0][STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output req_valid, req_reg, req_data, wb_hold,
        input  req_ready, rf_write, rf_writeReg, rf_writeData, pending, stall_cnt
    );

    modport slave (
        input  req_valid, req_reg, req_data, wb_hold,
        output req_ready, rf_write, rf_writeReg, rf_writeData, pending, stall_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter owning the rotation pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   i_req    : request vector
//   i_en     : grant enable; no grant while low
//   o_gnt    : one-hot grant (combinational)
//   o_idx    : encoded grant index (valid when o_vld)
//   o_vld    : a grant is made this cycle
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_en,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_vld
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_j;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = IW'((int'(r_ptr) + k) % NUM_REQ);
            if (!o_vld && i_en && i_req[w_j]) begin
                o_vld      = 1'b1;
                o_idx      = w_j;
                o_gnt[w_j] = 1'b1;
            end
        end
    end

    // Grant implies valid, so every grant is an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (o_vld)
            r_ptr <= (o_idx == IW'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port among NUM_REQ writeback
// requesters (round-robin), registers the granted write, and exports a
// pending-write bitmap for decode hazard logic.
//   clk, rst : clock, synchronous active-high reset
//   wb       : regfile_wb_arbiter_if.slave (requests, regfile write, pending,
//              stall counters)
// Optional: REGFILE_WB_ARB_STALL_CNT_EN enables saturating per-requester
// stall counters; otherwise stall_cnt is tied to 0.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_gnt_vld;
    logic               w_en;
    wb_req_t            w_sel;
    wb_req_t            r_out;
    logic               r_wr;
    logic [NUM_REGS-1:0] w_pend;

    assign w_en = !wb.wb_hold && !rst;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (wb.req_valid),
        .i_en  (w_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_gnt_vld)
    );

    assign wb.req_ready = w_gnt;

    always_comb begin
        w_sel.rd   = wb.req_reg[w_idx];
        w_sel.data = wb.req_data[w_idx];
    end

    // Output stage: address/data hold when idle, only the enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= 1'b0;
            r_out <= '0;
        end else if (w_gnt_vld) begin
            r_wr  <= 1'b1;
            r_out <= w_sel;
        end else begin
            r_wr  <= 1'b0;
        end
    end

    assign wb.rf_write     = r_wr;
    assign wb.rf_writeReg  = r_out.rd;
    assign wb.rf_writeData = r_out.data;

    // Any outstanding request or the registered write marks its target; x0
    // never reads as pending.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (wb.req_valid[i]) w_pend[wb.req_reg[i]] = 1'b1;
        if (r_wr) w_pend[r_out.rd] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign wb.pending = w_pend;

`ifdef REGFILE_WB_ARB_STALL_CNT_EN
    logic [NUM_REQ-1:0][STALL_CNT_W-1:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (wb.req_valid[i] && !w_gnt[i] && (r_stall[i] != '1))
                    r_stall[i] <= r_stall[i] + 1'b1;
        end
    end

    assign wb.stall_cnt = r_stall;
`else
    assign wb.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    // Scoreboard and reference state
    wb_req_t     sb[$];
    int          glog[$];
    logic [31:0] wlog[$];
    int          mptr = 0;
    logic [15:0] mst[N] = '{default: 16'h0};
    logic [4:0]  lrd = '0;
    logic [31:0] ldat = '0;
    logic        lv = 1'b0;

    always @(negedge clk) begin
        wb_req_t     e;
        logic [N-1:0] eg;
        logic [31:0] ep;
        logic [63:0] es;
        int          g;
        int          j;

        if (wb.rf_write === 1'b1) wlog.push_back(wb.rf_writeData);

        // Output stage vs scoreboard
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            lrd  = e.rd;
            ldat = e.data;
            lv   = 1'b1;
            chk("rf_write", wb.rf_write, 1);
        end else begin
            lv = 1'b0;
            chk("rf_write", wb.rf_write, 0);
        end
        chk("rf_writeReg", wb.rf_writeReg, lrd);
        chk("rf_writeData", wb.rf_writeData, ldat);

        // Pending bitmap
        ep = '0;
        for (int i = 0; i < N; i++)
            if (wb.req_valid[i]) ep[wb.req_reg[i]] = 1'b1;
        if (lv) ep[lrd] = 1'b1;
        ep[0] = 1'b0;
        chk("pending", wb.pending, ep);

        // Stall counters
        es = '0;
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
        for (int i = 0; i < N; i++) es[i*16 +: 16] = mst[i];
`endif
        chk("stall_cnt", wb.stall_cnt, es);

        // Expected grant this cycle
        g = -1;
        if (!rst && !wb.wb_hold)
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (g < 0 && wb.req_valid[j]) g = j;
            end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", wb.req_ready, eg);

        for (int k = 0; k < N; k++)
            if (wb.req_ready[k] === 1'b1) glog.push_back(k);

        if (rst) begin
            sb.delete();
            lrd  = '0;
            ldat = '0;
            mptr = 0;
            for (int i = 0; i < N; i++) mst[i] = '0;
        end else begin
            if (g >= 0) begin
                sb.push_back('{rd: wb.req_reg[g], data: wb.req_data[g]});
                mptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++)
                if (wb.req_valid[i] && i != g && mst[i] != 16'hFFFF) mst[i] = mst[i] + 16'd1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] v;
        wb.req_valid = '0;
        wb.req_reg   = '0;
        wb.req_data  = '0;
        wb.wb_hold   = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // Single request on requester 2
        wlog.delete(); glog.delete();
        wb.req_reg[2] = 5'd5; wb.req_data[2] = 32'hDEADBEEF; wb.req_valid = 4'b0100;
        cyc(1);
        wb.req_valid = '0;
        cyc(3);
        chk("single_nwr", wlog.size(), 1);
        chk("single_gnt", glog.size() == 1 ? glog[0] : -1, 2);
        chk("single_data", wlog.size() == 1 ? wlog[0] : 0, 32'hDEADBEEF);

        // Fairness from reset
        rst = 1'b1; cyc(1); rst = 1'b0;
        wlog.delete(); glog.delete();
        for (int i = 0; i < N; i++) begin
            wb.req_reg[i] = 5'(i + 1); wb.req_data[i] = 32'hA0 + i;
        end
        wb.req_valid = '1;
        cyc(8);
        wb.req_valid = '0;
        cyc(2);
        chk("fair_ngnt", glog.size(), 8);
        chk("fair_nwr", wlog.size(), 8);
        for (int k = 0; k < 8; k++)
            chk("fair_order", k < glog.size() ? glog[k] : -1, k % N);

        // Same-register collision, ptr back at 0
        wlog.delete();
        wb.req_reg[0] = 5'd7; wb.req_data[0] = 32'h1;
        wb.req_reg[1] = 5'd7; wb.req_data[1] = 32'h2;
        wb.req_valid = 4'b0011;
        cyc(1);
        wb.req_valid = 4'b0010;
        chk("coll_pend7_a", wb.pending[7], 1);
        cyc(1);
        wb.req_valid = '0;
        chk("coll_pend7_b", wb.pending[7], 1);
        cyc(1);
        chk("coll_pend7_c", wb.pending[7], 0);
        cyc(1);
        chk("coll_nwr", wlog.size(), 2);
        chk("coll_w0", wlog.size() > 0 ? wlog[0] : 0, 32'h1);
        chk("coll_w1", wlog.size() > 1 ? wlog[1] : 0, 32'h2);

        // Hold with requester 3 valid
        rst = 1'b1; cyc(1); rst = 1'b0;
        glog.delete();
        wb.wb_hold = 1'b1;
        wb.req_reg[3] = 5'd9; wb.req_data[3] = 32'h33; wb.req_valid = 4'b1000;
        cyc(3);
        chk("hold_nogrant", glog.size(), 0);
        wb.wb_hold = 1'b0;
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
        chk("hold_stall3", wb.stall_cnt[3], 3);
`else
        chk("hold_stall3", wb.stall_cnt[3], 0);
`endif
        cyc(1);
        wb.req_valid = '0;
        chk("hold_gnt", glog.size() == 1 ? glog[0] : -1, 3);
        cyc(2);

        // Reset mid-stream
        glog.delete();
        wb.req_valid = '1;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_wr", wb.rf_write, 0);
        chk("rst_stall", wb.stall_cnt, 0);
        cyc(4);
        wb.req_valid = '0;
        cyc(2);
        chk("rst_ngnt", glog.size(), 5);
        for (int k = 0; k < 5; k++)
            chk("rst_order", k < glog.size() ? glog[k] : -1, (k == 0) ? 0 : k - 1);

        // x0 write
        wlog.delete();
        wb.req_reg[1] = 5'd0; wb.req_data[1] = 32'h55; wb.req_valid = 4'b0010;
        cyc(1);
        wb.req_valid = '0;
        chk("x0_wr", wb.rf_write, 1);
        chk("x0_reg", wb.rf_writeReg, 0);
        chk("x0_pend0", wb.pending[0], 0);
        cyc(2);
        chk("x0_data", wlog.size() == 1 ? wlog[0] : 0, 32'h55);

        // Random traffic; reg/data change only while a lane is idle
        for (int c = 0; c < 200; c++) begin
            v = wb.req_valid;
            for (int i = 0; i < N; i++) begin
                if (!v[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    wb.req_reg[i]  = 5'($urandom_range(0, 31));
                    wb.req_data[i] = $urandom;
                end else if ($urandom_range(0, 5) == 0) begin
                    v[i] = 1'b0;
                end
            end
            wb.req_valid = v;
            wb.wb_hold   = ($urandom_range(0, 4) == 0);
            rst          = ($urandom_range(0, 40) == 0);
            cyc(1);
        end
        rst = 1'b0; wb.wb_hold = 1'b0; wb.req_valid = '0;
        cyc(3);
        chk("drain_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
